// File: rtl/joypad_pkg.sv
// -----------------------------------------------------------------------------
// joypad_pkg
// Shared constants for the Game Boy P1/JOYP joypad register block.
//   - Button bit positions within the 8-bit button vectors
//     ({start, select, b, a, down, up, left, right}).
//   - P1 register address and the constant value of its unused top bits.
//   - select_nibble(): the P1 read nibble built from the debounced buttons
//     and the two group-select bits.
// -----------------------------------------------------------------------------
package joypad_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_START  = 7;

    localparam logic [15:0] P1_ADDR   = 16'hFF00;
    localparam logic [1:0]  P1_UNUSED = 2'b11;

    // Active-low select bits: sel[0]=0 exposes the direction group
    // (stable[3:0]), sel[1]=0 exposes the action group (stable[7:4]).
    // With both groups selected the lines are wire-ANDed, as on the console.
    function automatic logic [3:0] select_nibble(input logic [1:0] sel,
                                                 input logic [7:0] stable);
        logic [3:0] dir_grp;
        logic [3:0] act_grp;
        dir_grp = sel[0] ? 4'hF : stable[3:0];
        act_grp = sel[1] ? 4'hF : stable[7:4];
        return dir_grp & act_grp;
    endfunction

endpackage

// File: rtl/joypad_debounce.sv
// -----------------------------------------------------------------------------
// joypad_debounce
// One button line: two-flop synchroniser followed by a counting debouncer.
// The stable output only follows the synchronised input after it has differed
// from the current stable value for DEBOUNCE_CYCLES consecutive cycles; any
// return to the stable value restarts the qualification.
//
// Ports:
//   clock     in   CPU clock, all state on the rising edge
//   reset     in   synchronous, active-high
//   button_n  in   raw asynchronous button line, active-low
//   stable    out  debounced button level, active-low (reset 1 = released)
// -----------------------------------------------------------------------------
module joypad_debounce
    import joypad_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 20000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
            stable    <= 1'b1;
            count     <= '0;
        end else begin
            sync_meta <= button_n;
            sync      <= sync_meta;
            if (sync == stable) begin
                // Input agrees with the accepted level: any partial
                // qualification was a glitch, start over.
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= sync;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/joypad_controller.sv
// -----------------------------------------------------------------------------
// joypad_controller
// Game Boy P1/JOYP register block (address 0xFF00). Debounces the eight board
// buttons, holds the group-select bits written by the CPU, presents the
// selected nibble on the read path and pulses joypad_int whenever a visible
// nibble bit goes from 1 to 0 (a press, or a select write exposing a button
// that is already held).
//
// Ports:
//   clock           in   CPU clock, all state on the rising edge
//   reset           in   synchronous, active-high
//   buttons_n[7:0]  in   raw buttons, active-low, {start,select,b,a,down,up,left,right}
//   wren            in   write strobe, already decoded for 0xFF00
//   data_in[7:0]    in   CPU write data, bits 5:4 land in the select register
//   data_out[7:0]   out  P1 read value {2'b11, sel, nibble}
//   joypad_int      out  one-cycle interrupt request pulse
//   buttons_stable  out  debounced buttons, active-low, same order as buttons_n
// -----------------------------------------------------------------------------
module joypad_controller
    import joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] buttons_n,
    input  logic       wren,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       joypad_int,
    output logic [7:0] buttons_stable
);

    logic [1:0] sel;
    logic [3:0] nib;
    logic [3:0] prev_nib;
    logic       unused_data_bits;

    // Only bits 5:4 of a P1 write are writable.
    assign unused_data_bits = ^{data_in[7:6], data_in[3:0]};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        joypad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock    (clock),
            .reset    (reset),
            .button_n (buttons_n[i]),
            .stable   (buttons_stable[i])
        );
    end

    assign nib      = select_nibble(sel, buttons_stable);
    assign data_out = {P1_UNUSED, sel, nib};

    // wren is a plain one-cycle write strobe: there is no ready/back-pressure,
    // the register accepts the write on the edge where wren is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel        <= 2'b11;
            prev_nib   <= 4'hF;
            joypad_int <= 1'b0;
        end else begin
            if (wren) begin
                sel <= data_in[5:4];
            end
            prev_nib   <= nib;
            // Any bit that was 1 last cycle and is 0 now; several bits
            // falling together still give a single pulse.
            joypad_int <= |(prev_nib & ~nib);
        end
    end

endmodule

// File: tb/tb_joypad_controller.sv
// -----------------------------------------------------------------------------
// tb_joypad_controller
// Directed scenarios for joypad_controller with DEBOUNCE_CYCLES=4. The driver
// schedules expected data_out/buttons_stable values and interrupt pulse cycles
// into queues; the monitor samples on every falling edge and checks whatever
// is due that cycle, including joypad_int against the expected pulse schedule.
// -----------------------------------------------------------------------------
module tb_joypad_controller;
    import joypad_pkg::*;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] buttons_n;
    logic       wren;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       joypad_int;
    logic [7:0] buttons_stable;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [7:0] dout;
        logic [7:0] stab;
        string      name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] int_q[$];

    joypad_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock          (clock),
        .reset          (reset),
        .buttons_n      (buttons_n),
        .wren           (wren),
        .data_in        (data_in),
        .data_out       (data_out),
        .joypad_int     (joypad_int),
        .buttons_stable (buttons_stable)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic want(input int off, input logic [7:0] d, input logic [7:0] s,
                        input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.dout = d;
        e.stab = s;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic want_int(input int off);
        int_q.push_back(32'(cyc + off));
    endtask

    // Write P1; on return the new select value is already visible.
    task automatic write_p1(input logic [7:0] d);
        data_in = d;
        wren    = 1'b1;
        step(1);
        wren    = 1'b0;
        data_in = 8'h00;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic exp_int;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: check for cycle %0d was never sampled", exp_q[i].name, exp_q[i].cyc);
                exp_q.delete(i);
            end else if (exp_q[i].cyc == cyc) begin
                checks++;
                if (data_out !== exp_q[i].dout) begin
                    failures++;
                    $display("FAIL %s data_out @%0d: got %h expected %h",
                             exp_q[i].name, cyc, data_out, exp_q[i].dout);
                end
                checks++;
                if (buttons_stable !== exp_q[i].stab) begin
                    failures++;
                    $display("FAIL %s buttons_stable @%0d: got %h expected %h",
                             exp_q[i].name, cyc, buttons_stable, exp_q[i].stab);
                end
                exp_q.delete(i);
            end
        end

        exp_int = 1'b0;
        if (int_q.size() > 0 && int_q[0] == 32'(cyc)) begin
            exp_int = 1'b1;
            void'(int_q.pop_front());
        end
        checks++;
        if (joypad_int !== exp_int) begin
            failures++;
            $display("FAIL joypad_int @%0d: got %b expected %b", cyc, joypad_int, exp_int);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        buttons_n = 8'hFF;
        wren      = 1'b0;
        data_in   = 8'h00;
        step(3);
        want(0, 8'hFF, 8'hFF, "reset_state");
        reset = 1'b0;

        // 1. Idle after reset: nothing changes for 10 cycles.
        for (int k = 1; k <= 10; k++) want(k, 8'hFF, 8'hFF, "idle");
        step(10);

        // 2. A low for 3 cycles (one short of DEB) must be rejected.
        for (int k = 1; k <= 12; k++) want(k, 8'hFF, 8'hFF, "glitch");
        buttons_n[BTN_A] = 1'b0;
        step(3);
        buttons_n[BTN_A] = 1'b1;
        step(12);

        // 3. Select action group, press A: stable 2+DEB cycles later, int next.
        write_p1(8'h10);
        want(0, 8'hDF, 8'hFF, "sel_action");
        buttons_n[BTN_A] = 1'b0;
        want(5, 8'hDF, 8'hFF, "a_not_yet");
        want(6, 8'hDE, 8'hEF, "a_press");
        want_int(7);
        want(12, 8'hDE, 8'hEF, "a_hold");
        step(15);
        buttons_n[BTN_A] = 1'b1;
        want(5, 8'hDE, 8'hEF, "a_release_pending");
        want(6, 8'hDF, 8'hFF, "a_release");
        step(10);

        // 4. Down held while hidden, then exposed by a select write.
        write_p1(8'h30);
        want(0, 8'hFF, 8'hFF, "sel_none");
        buttons_n[BTN_DOWN] = 1'b0;
        want(6, 8'hFF, 8'hF7, "down_hidden");
        step(10);
        write_p1(8'h20);
        want(0, 8'hE7, 8'hF7, "down_exposed");
        want_int(1);
        step(5);
        buttons_n[BTN_DOWN] = 1'b1;
        want(6, 8'hEF, 8'hFF, "down_release");
        step(10);

        // 5. Start and Right, both groups selected: wire-AND 7 & E = 6.
        write_p1(8'h30);
        want(0, 8'hFF, 8'hFF, "sel_none2");
        buttons_n[BTN_START] = 1'b0;
        buttons_n[BTN_RIGHT] = 1'b0;
        want(6, 8'hFF, 8'h7E, "start_right");
        step(10);
        write_p1(8'h00);
        want(0, 8'hC6, 8'h7E, "both_groups");
        want_int(1);
        step(5);
        buttons_n[BTN_RIGHT] = 1'b1;
        want(6, 8'hC7, 8'h7F, "right_release");
        step(10);
        buttons_n[BTN_START] = 1'b1;
        want(6, 8'hCF, 8'hFF, "start_release");
        step(10);

        // 6. Reset at debounce count 2 discards the press; B re-qualifies.
        write_p1(8'h10);
        want(0, 8'hDF, 8'hFF, "sel_action2");
        buttons_n[BTN_B] = 1'b0;
        step(4);
        want(0, 8'hDF, 8'hFF, "b_mid_debounce");
        reset = 1'b1;
        want(1, 8'hFF, 8'hFF, "reset_mid");
        step(1);
        reset = 1'b0;
        want(5, 8'hFF, 8'hFF, "b_requal_pending");
        want(6, 8'hFF, 8'hDF, "b_requal");
        step(10);
        write_p1(8'h10);
        want(0, 8'hDD, 8'hDF, "b_sel_action");
        want_int(1);
        step(5);
        buttons_n[BTN_B] = 1'b1;
        step(10);

        checks++;
        if (exp_q.size() != 0 || int_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations: got %0d/%0d pending expected 0/0",
                     exp_q.size(), int_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
